serial_add32: RTL

Byte-serial multi-byte adder that wraps one `selectAdd8` carry-select adder. It splits two `8*NBYTES`-bit operands into bytes and feeds one byte pair per cycle, LSB first, into the `selectAdd8` instance. The carry is chained across cycles through a register, and the result bytes are collected in a sum register. It sits directly around `selectAdd8`: it supplies the adder's `a`, `b` and `cin` and consumes its `sum` and `cout`.

---
 rtl/serial_add32.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/serial_add32.sv
// serial_add32: byte-serial multi-byte adder built around one selectAdd8
// carry-select adder. Each cycle one byte pair is summed, starting with the
// least-significant byte. A register carries the carry from one cycle to the next.
// Optional feature macro: SERIAL_ADD_OVF_EN adds a registered signed-overflow
// output 'ovf'.

// selectAdd8: 8-bit carry-select adder. The low nibble is a ripple add.
// The high nibble is precomputed for both carry-in values, and the low
// nibble's carry selects one of the two results.
module selectAdd8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    // low nibble ripple and both speculative high-nibble sums
    always_comb begin
        lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
        hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    end

    // carry from the low nibble selects the high-nibble result
    always_comb begin
        sum[3:0] = lo[3:0];
        if (lo[4]) begin
            sum[7:4] = hi1[3:0];
            cout     = hi1[4];
        end else begin
            sum[7:4] = hi0[3:0];
            cout     = hi0[4];
        end
    end

endmodule

module serial_add32 #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic                ovf,
`endif
    output logic                cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] idx;
    logic [IW+2:0] off;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry;
    logic          last;
    logic          load;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic [7:0]    add_sum;
    logic          add_cout;

    // bit offset of the current byte
    assign off  = {idx, 3'b000};
    assign last = (idx == IW'(NBYTES - 1));

    // present the current byte pair to the adder
    always_comb begin
        add_a = a_reg[off +: 8];
        add_b = b_reg[off +: 8];
    end

    selectAdd8 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load     = 1'b1;
                    state_nx = ADD;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // operand capture, carry chain, byte index and result collection
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == ADD) begin
            sum[off +: 8] <= add_sum;
            carry         <= add_cout;
            if (last) begin
                cout <= add_cout;
                idx  <= '0;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // signed overflow, registered on the final byte together with sum
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (state == ADD && last) begin
            ovf <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[7] != a_reg[W-1]);
        end
    end
`endif

endmodule
